// File: rtl/bnn_pkg.sv
// bnn_pkg -- shared definitions for the binary neural network layer engine.
//
// Contents:
//   bnn_state_e : controller states (IDLE, FETCH, DRAIN, STORE, DONE)
//   words_f     : number of RAM words per neuron input vector (in_len / lanes)
//   acc_w_f     : width of an unsigned counter able to hold 0..n
//   idx_w_f     : width of an index counting 0..count-1 (at least 1 bit)
//
// The optional runtime threshold of the engine is enabled with the
// BNN_THRESHOLD_EN macro (see bnn_layer_engine.sv).

package bnn_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      DRAIN = 3'd2,
      STORE = 3'd3,
      DONE  = 3'd4
   } bnn_state_e;

   function automatic int words_f(input int in_len, input int lanes);
      return in_len / lanes;
   endfunction

   function automatic int acc_w_f(input int n);
      return $clog2(n + 1);
   endfunction

   function automatic int idx_w_f(input int count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

endpackage

// File: rtl/bnn_popcount.sv
// bnn_popcount -- combinational population count of a LANES-bit vector.
//
// Ports:
//   bits  in   LANES               vector to count
//   count out  acc_w_f(LANES)      number of ones in bits (0..LANES)

module bnn_popcount
   import bnn_pkg::*;
#(
   parameter int LANES = 8
) (
   input  logic [LANES-1:0]          bits,
   output logic [acc_w_f(LANES)-1:0] count
);

   localparam int CNT_W = acc_w_f(LANES);

   // Each lane widened to the full count width so the summing loop below
   // works on equally sized operands.
   logic [CNT_W-1:0] lane_cnt [LANES];

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_cnt[gi] = CNT_W'(bits[gi]);
   end

   always_comb begin
      count = '0;
      for (int i = 0; i < LANES; i++) begin
         count = count + lane_cnt[i];
      end
   end

endmodule

// File: rtl/bnn_layer_engine.sv
// bnn_layer_engine -- computes one fully connected binary layer.
// For each neuron n the input vector (input RAM) is XNOR-ed with the
// neuron's weight vector (weight RAM, neuron-major) LANES bits at a time,
// matches are counted, and the activation (signed sum >= threshold) is
// written to the output RAM at address n.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   start                    run request, accepted only in IDLE
//   busy                     high in FETCH, DRAIN, STORE
//   done                     one-cycle pulse after the last neuron is stored
//   in_rd_en/in_addr/in_data input RAM read port (1-cycle latency)
//   w_rd_en/w_addr/w_data    weight RAM read port (1-cycle latency)
//   out_we/out_addr/out_bit  activation write port
//   thr                      signed threshold, present only with BNN_THRESHOLD_EN;
//                            captured when start is accepted
//
// Macro BNN_THRESHOLD_EN: adds port thr; otherwise the threshold is 0.

module bnn_layer_engine
   import bnn_pkg::*;
#(
   parameter int IN_LEN     = 1024,
   parameter int NEURONS    = 64,
   parameter int LANES      = 8,
   parameter int I_ADDR_LEN = 10,
   parameter int W_ADDR_LEN = 17,
   parameter int O_ADDR_LEN = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  in_rd_en,
   output logic [I_ADDR_LEN-1:0] in_addr,
   input  logic [LANES-1:0]      in_data,
   output logic                  w_rd_en,
   output logic [W_ADDR_LEN-1:0] w_addr,
   input  logic [LANES-1:0]      w_data,
   output logic                  out_we,
   output logic [O_ADDR_LEN-1:0] out_addr,
   output logic                  out_bit
`ifdef BNN_THRESHOLD_EN
   ,
   input  logic signed [acc_w_f(IN_LEN):0] thr
`endif
);

   localparam int WORDS = words_f(IN_LEN, LANES);
   localparam int ACC_W = acc_w_f(IN_LEN);
   localparam int PC_W  = acc_w_f(LANES);
   localparam int K_W   = idx_w_f(WORDS);
   localparam int N_W   = idx_w_f(NEURONS);

   localparam logic [K_W-1:0] K_LAST = K_W'(WORDS - 1);
   localparam logic [N_W-1:0] N_LAST = N_W'(NEURONS - 1);

   if ((IN_LEN % LANES) != 0) begin : g_bad_len
      $error("bnn_layer_engine: IN_LEN must be a multiple of LANES");
   end

   bnn_state_e            state_reg, state_next;
   logic [K_W-1:0]        k_reg, k_next;
   logic [N_W-1:0]        n_reg, n_next;
   // Weight address runs n*WORDS+k; since words are fetched in order across
   // neurons it is simply a running counter, no multiplier needed.
   logic [W_ADDR_LEN-1:0] w_ptr_reg, w_ptr_next;
   logic [ACC_W-1:0]      acc_reg;
   logic                  rd_pend_reg;   // a read was issued last cycle
   logic                  acc_clr;
   logic                  act_bit;

   logic [LANES-1:0]      match_bits;
   logic [PC_W-1:0]       match_cnt;

   assign match_bits = ~(in_data ^ w_data);

   bnn_popcount #(
      .LANES (LANES)
   ) u_popcount (
      .bits  (match_bits),
      .count (match_cnt)
   );

   // Activation decision on the completed match count.
`ifdef BNN_THRESHOLD_EN
   localparam logic signed [ACC_W+1:0] IN_LEN_S = (ACC_W+2)'(IN_LEN);

   logic signed [ACC_W:0]   thr_reg;
   logic signed [ACC_W+1:0] sum_s;
   logic signed [ACC_W+1:0] thr_ext;

   assign sum_s   = $signed({1'b0, acc_reg, 1'b0}) - IN_LEN_S;
   assign thr_ext = {thr_reg[ACC_W], thr_reg};
   assign act_bit = (sum_s >= thr_ext);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         thr_reg <= '0;
      end else if ((state_reg == IDLE) && start) begin
         thr_reg <= thr;
      end
   end
`else
   localparam logic [ACC_W:0] IN_LEN_U = (ACC_W+1)'(IN_LEN);

   // 2*matches >= IN_LEN is the same as signed sum >= 0; ties give 1.
   assign act_bit = ({acc_reg, 1'b0} >= IN_LEN_U);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         k_reg       <= '0;
         n_reg       <= '0;
         w_ptr_reg   <= '0;
         acc_reg     <= '0;
         rd_pend_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         k_reg       <= k_next;
         n_reg       <= n_next;
         w_ptr_reg   <= w_ptr_next;
         rd_pend_reg <= (state_reg == FETCH);
         // RAM data arrives one cycle after the address, so accumulation
         // trails the fetch by one cycle and finishes in DRAIN.
         if (acc_clr) begin
            acc_reg <= '0;
         end else if (rd_pend_reg) begin
            acc_reg <= acc_reg + ACC_W'(match_cnt);
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      k_next     = k_reg;
      n_next     = n_reg;
      w_ptr_next = w_ptr_reg;
      acc_clr    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      in_rd_en   = 1'b0;
      w_rd_en    = 1'b0;
      out_we     = 1'b0;
      out_bit    = 1'b0;
      in_addr    = '0;
      w_addr     = '0;
      out_addr   = '0;

      unique case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = FETCH;
               k_next     = '0;
               n_next     = '0;
               w_ptr_next = '0;
               acc_clr    = 1'b1;
            end
         end
         FETCH: begin
            busy       = 1'b1;
            in_rd_en   = 1'b1;
            w_rd_en    = 1'b1;
            in_addr    = I_ADDR_LEN'(k_reg);
            w_addr     = w_ptr_reg;
            w_ptr_next = w_ptr_reg + W_ADDR_LEN'(1);
            if (k_reg == K_LAST) begin
               k_next     = '0;
               state_next = DRAIN;
            end else begin
               k_next = k_reg + K_W'(1);
            end
         end
         DRAIN: begin
            busy       = 1'b1;
            state_next = STORE;
         end
         STORE: begin
            busy     = 1'b1;
            out_we   = 1'b1;
            out_addr = O_ADDR_LEN'(n_reg);
            out_bit  = act_bit;
            acc_clr  = 1'b1;
            if (n_reg == N_LAST) begin
               state_next = DONE;
            end else begin
               n_next     = n_reg + N_W'(1);
               state_next = FETCH;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_bnn_layer_engine.sv
// tb_bnn_layer_engine -- self-checking bench for bnn_layer_engine.
// Configuration IN_LEN=16, LANES=8, NEURONS=2. Input and weight RAMs are
// modelled as 1-cycle-latency arrays; activations are predicted from the
// +1/-1 dot product of each neuron's vectors.
// With BNN_THRESHOLD_EN defined the threshold port and its test are included.

module tb_bnn_layer_engine;

   localparam int IN_LEN     = 16;
   localparam int LANES      = 8;
   localparam int NEURONS    = 2;
   localparam int I_ADDR_LEN = 4;
   localparam int W_ADDR_LEN = 6;
   localparam int O_ADDR_LEN = 4;
   localparam int WORDS      = IN_LEN / LANES;
   localparam int LATENCY    = NEURONS * (WORDS + 2) + 1;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start;
   logic                  busy;
   logic                  done;
   logic                  in_rd_en;
   logic [I_ADDR_LEN-1:0] in_addr;
   logic [LANES-1:0]      in_data = '0;
   logic                  w_rd_en;
   logic [W_ADDR_LEN-1:0] w_addr;
   logic [LANES-1:0]      w_data = '0;
   logic                  out_we;
   logic [O_ADDR_LEN-1:0] out_addr;
   logic                  out_bit;
`ifdef BNN_THRESHOLD_EN
   logic signed [5:0]     thr = '0;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int thr_model = 0;

   logic [LANES-1:0] in_mem [2**I_ADDR_LEN];
   logic [LANES-1:0] w_mem  [2**W_ADDR_LEN];

   int cyc = 0;
   int we_addr_q [$];
   bit we_bit_q  [$];
   int done_cnt = 0;
   int done_cyc = -1;

   bnn_layer_engine #(
      .IN_LEN     (IN_LEN),
      .NEURONS    (NEURONS),
      .LANES      (LANES),
      .I_ADDR_LEN (I_ADDR_LEN),
      .W_ADDR_LEN (W_ADDR_LEN),
      .O_ADDR_LEN (O_ADDR_LEN)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .in_rd_en (in_rd_en),
      .in_addr  (in_addr),
      .in_data  (in_data),
      .w_rd_en  (w_rd_en),
      .w_addr   (w_addr),
      .w_data   (w_data),
      .out_we   (out_we),
      .out_addr (out_addr),
      .out_bit  (out_bit)
`ifdef BNN_THRESHOLD_EN
      ,
      .thr      (thr)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (in_rd_en) in_data <= in_mem[in_addr];
      if (w_rd_en)  w_data  <= w_mem[w_addr];
   end

   always @(negedge clk) begin
      if (out_we) begin
         we_addr_q.push_back(int'(out_addr));
         we_bit_q.push_back(out_bit);
      end
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   // Reference: +1/-1 dot product of input vector and weight vector n.
   function automatic bit model_bit(input int n, input int thr_v);
      int s;
      s = 0;
      for (int w = 0; w < WORDS; w++) begin
         for (int b = 0; b < LANES; b++) begin
            if (in_mem[w][b] == w_mem[n * WORDS + w][b]) s = s + 1;
            else s = s - 1;
         end
      end
      return (s >= thr_v);
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 2**I_ADDR_LEN; i++) in_mem[i] = LANES'($urandom);
      for (int i = 0; i < 2**W_ADDR_LEN; i++) w_mem[i]  = LANES'($urandom);
   endtask

   task automatic fill_const(input logic [LANES-1:0] iv, input logic [LANES-1:0] wv);
      fill_random();
      for (int i = 0; i < WORDS; i++) in_mem[i] = iv;
      for (int i = 0; i < NEURONS * WORDS; i++) w_mem[i] = wv;
   endtask

   task automatic clear_monitor();
      we_addr_q.delete();
      we_bit_q.delete();
      done_cnt = 0;
      done_cyc = -1;
   endtask

   // One complete run; restart_cyc > 0 pulses start again during that cycle.
   task automatic run_check(input string name, input int restart_cyc);
      bit exp_bits [NEURONS];
      int s;
      int waited;
      for (int n = 0; n < NEURONS; n++) exp_bits[n] = model_bit(n, thr_model);
      @(negedge clk);
      clear_monitor();
`ifdef BNN_THRESHOLD_EN
      thr = 6'(thr_model);
`endif
      s = cyc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
      end
      waited = 1;
      while (done_cnt == 0 && waited < 200) begin
         start = (restart_cyc > 0 && waited == restart_cyc - 1);
         @(negedge clk);
         waited++;
      end
      start = 1'b0;
      n_checks++;
      if (done_cnt == 0) begin
         n_fail++;
         $display("FAIL %s done_timeout: got no done within %0d cycles expected done", name, waited);
      end else begin
         n_checks++;
         if (done_cyc - s !== LATENCY) begin
            n_fail++;
            $display("FAIL %s done_latency: got %0d expected %0d", name, done_cyc - s, LATENCY);
         end
         n_checks++;
         if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_at_done: got %b expected 0", name, busy);
         end
      end
      repeat (6) @(negedge clk);
      n_checks++;
      if (done_cnt !== 1) begin
         n_fail++;
         $display("FAIL %s done_count: got %0d expected 1", name, done_cnt);
      end
      n_checks++;
      if (we_addr_q.size() !== NEURONS) begin
         n_fail++;
         $display("FAIL %s we_count: got %0d expected %0d", name, we_addr_q.size(), NEURONS);
      end
      for (int n = 0; n < NEURONS && n < we_addr_q.size(); n++) begin
         $display("%s: write %0d addr %0d bit %0b (expected addr %0d bit %0b)",
                  name, n, we_addr_q[n], we_bit_q[n], n, exp_bits[n]);
         n_checks++;
         if (we_addr_q[n] !== n) begin
            n_fail++;
            $display("FAIL %s out_addr[%0d]: got %0d expected %0d", name, n, we_addr_q[n], n);
         end
         n_checks++;
         if (we_bit_q[n] !== exp_bits[n]) begin
            n_fail++;
            $display("FAIL %s out_bit[%0d]: got %0b expected %0b", name, n, we_bit_q[n], exp_bits[n]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({busy, done, in_rd_en, w_rd_en, out_we, out_bit, in_addr, w_addr, out_addr} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected all zero",
                  {busy, done, in_rd_en, w_rd_en, out_we, out_bit, in_addr, w_addr, out_addr});
      end
      $display("reset: outputs busy=%b done=%b out_we=%b", busy, done, out_we);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      fill_const(8'hFF, 8'hFF);
      run_check("all_match", 0);
      fill_const(8'hFF, 8'h00);
      run_check("no_match", 0);
      fill_const(8'hFF, 8'hF0);
      run_check("tie", 0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         fill_random();
         run_check("random", 0);
      end
   endtask

   task automatic test_back_to_back();
      fill_random();
      run_check("start_while_busy", 3);
      fill_random();
      run_check("back_to_back", 0);
   endtask

   task automatic test_midrun_reset();
      fill_random();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if ({busy, done, in_rd_en, w_rd_en, out_we, out_bit, in_addr, w_addr, out_addr} !== '0) begin
         n_fail++;
         $display("FAIL midrun_reset_outputs: got %b expected all zero",
                  {busy, done, in_rd_en, w_rd_en, out_we, out_bit, in_addr, w_addr, out_addr});
      end
      @(negedge clk);
      rst = 1'b0;
      clear_monitor();
      repeat (12) @(negedge clk);
      $display("midrun_reset: writes after abort %0d, done pulses %0d", we_addr_q.size(), done_cnt);
      n_checks++;
      if (we_addr_q.size() !== 0 || done_cnt !== 0) begin
         n_fail++;
         $display("FAIL midrun_reset_quiet: got %0d writes %0d done expected 0 and 0",
                  we_addr_q.size(), done_cnt);
      end
      fill_random();
      run_check("restart_after_reset", 0);
   endtask

`ifdef BNN_THRESHOLD_EN
   task automatic test_threshold();
      fill_const(8'hFF, 8'hFF);
      for (int n = 0; n < NEURONS; n++) w_mem[n * WORDS + 1] = 8'h01;
      thr_model = 4;
      run_check("thr4_sum2", 0);
      thr_model = 2;
      run_check("thr2_sum2", 0);
      for (int r = 0; r < 3; r++) begin
         fill_random();
         thr_model = $urandom_range(0, 12) - 6;
         run_check("thr_random", 0);
      end
      thr_model = 0;
   endtask
`endif

   initial begin
      rst = 1'b1;
      start = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_midrun_reset();
`ifdef BNN_THRESHOLD_EN
      test_threshold();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bnn_layer_engine.md
BNN_LAYER_ENGINE -- requirements
Module: bnn_layer_engine

Interface
REQ-001 SHALL have parameter IN_LEN, default 1024, meaning input bits per neuron.
REQ-002 SHALL have parameter NEURONS, default 64, meaning output neurons per run.
REQ-003 SHALL have parameter LANES, default 8, meaning bits per input/weight RAM word; IN_LEN % LANES != 0 is an elaboration error.
REQ-004 SHALL have parameters I_ADDR_LEN, default 10, W_ADDR_LEN, default 17, and O_ADDR_LEN, default 10, meaning RAM address widths.
REQ-005 SHALL have ports: clk  in  1  clock, all logic on the rising edge.
REQ-006 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports: start  in  1  run request; busy  out  1  run in progress; done  out  1  one-cycle completion pulse.
REQ-008 SHALL have ports: in_rd_en  out  1; in_addr  out  I_ADDR_LEN; in_data  in  LANES  input-RAM read data.
REQ-009 SHALL have ports: w_rd_en  out  1; w_addr  out  W_ADDR_LEN; w_data  in  LANES  weight-RAM read data.
REQ-010 SHALL have ports: out_we  out  1; out_addr  out  O_ADDR_LEN; out_bit  out  1  activation write.

Function
REQ-011 SHALL use WORDS = IN_LEN/LANES; bit value 1 = +1, bit value 0 = -1.
REQ-012 SHALL treat both RAMs as synchronous with exactly 1-cycle read latency: data for an address issued in cycle t is valid in cycle t+1.
REQ-013 SHALL use states IDLE, FETCH, DRAIN, STORE, DONE.
REQ-014 IDLE: start=1 -> FETCH with neuron n=0, word k=0, and accumulator cleared; start while busy=1 SHALL be ignored.
REQ-015 FETCH: each cycle SHALL assert in_rd_en and w_rd_en, with in_addr=k and w_addr=n*WORDS+k; after k=WORDS-1 -> DRAIN.
REQ-016 SHALL add popcount(~(in_data ^ w_data)) to an unsigned match counter of width clog2(IN_LEN+1) in the cycle after each read (FETCH cycles 2..WORDS and the DRAIN cycle).
REQ-017 STORE: SHALL assert out_we=1, out_addr=n, and out_bit = (2*matches >= IN_LEN), i.e. signed sum >= 0.
REQ-018 After STORE, SHALL clear the accumulator; if n<NEURONS-1 -> FETCH with n+1, otherwise -> DONE.
REQ-019 DONE: SHALL assert done=1 for exactly one cycle, then -> IDLE.
REQ-020 Per-neuron latency SHALL be WORDS+2 cycles; done SHALL be high NEURONS*(WORDS+2)+1 cycles after the start edge.
REQ-021 busy SHALL be 1 in FETCH, DRAIN, and STORE, and 0 in IDLE and DONE.
REQ-022 Read enables and out_we SHALL be 0 in every state where they are not explicitly asserted; addresses in those states are don't-care.
REQ-023 The accumulator SHALL NOT overflow by construction (max value IN_LEN).

Reset
REQ-024 rst SHALL force IDLE immediately and set busy, done, in_rd_en, w_rd_en, out_we, out_bit, all addresses, and the accumulator to 0.
REQ-025 rst asserted mid-run SHALL abort the run with no further out_we or done; the next start SHALL begin at neuron 0.

Configuration
REQ-026 With BNN_THRESHOLD_EN defined, SHALL add input port thr (signed, clog2(IN_LEN+1)+1 bits), sampled on the accepted start; out_bit = (2*matches - IN_LEN >= thr).
REQ-027 Without BNN_THRESHOLD_EN, port thr SHALL be absent and the threshold fixed at 0 (REQ-017).

Structure
REQ-028 The state enum and the WORDS and accumulator-width calculation functions SHALL live in the shared package bnn_pkg.
REQ-029 Popcount SHALL be a separate sub-module, bnn_popcount, combinational and parameterised by LANES.

Verification
REQ-030 IN_LEN=16, LANES=8, NEURONS=2, inputs = weights = 8'hFF -> out_bit=1 for both neurons; done in cycle 9.
REQ-031 Inputs 8'hFF, weights 8'h00 -> matches=0 -> out_bit=0; out_addr sequence 0, 1.
REQ-032 Inputs 8'hFF, weights 8'hF0 -> matches=8, sum 0 -> out_bit=1 (tie resolves to 1).
REQ-033 start pulsed again in cycle 3 of a run -> ignored; exactly 2 out_we pulses and 1 done.
REQ-034 rst in cycle 4 -> all outputs 0 next cycle, no done; a restart produces correct results.
REQ-035 BNN_THRESHOLD_EN defined, thr=4, matches=9 (sum 2) -> out_bit=0; thr=2 -> out_bit=1.
